neuron_param_fetcher: RTL and testbench
=======================================

// Module: neuron_param_fetcher
// PURPOSE
// - Reads one neuron's parameters from external flash and streams them to the MAC datapath.
// - Drives the flash read interface (ce/oe/we/address/data) and captures 16-bit words.
// - For each selected neuron, emits the bias word first, then the packed 4-bit weights.
// - Flash map: 8 hidden neurons x (1 bias + 36 weight words) at 0..295;
//   10 output neurons x (1 bias + 2 weight words) at 296..325.
// PARAMETERS
// - ADDR_W       16   flash address width
// - DATA_W       16   flash data / bias width
// - READ_WAIT     2   cycles the address is held before fm_data is sampled (>=1)
// - HID_NEURONS   8   hidden-layer neuron count
// - HID_WORDS    36   weight words per hidden neuron (144 nibbles)
// - OUT_NEURONS  10   output-layer neuron count
// - OUT_WORDS     2   weight words per output neuron (8 nibbles)
// PORTS
// - clk           in   1       system clock, all logic on rising edge
// - rst           in   1       synchronous, active-high reset
// - start         in   1       fetch request, sampled only in IDLE
// - layer         in   1       0 = hidden, 1 = output
// - neuron_idx    in   4       neuron index within the layer
// - fm_data       in   16      flash read data
// - fm_address    out  ADDR_W  flash word address
// - fm_ce, fm_oe  out  1       flash chip/output enable, active-high, asserted only in ADDR
// - fm_we         out  1       flash write enable, constant 0
// - bias          out  16      bias word, valid with bias_valid
// - bias_valid    out  1       bias available; held until bias_ready
// - bias_ready    in   1       consumer accepts bias
// - weight        out  4       raw weight nibble, valid with weight_valid
// - weight_valid  out  1       nibble available; held until weight_ready
// - weight_ready  in   1       consumer accepts nibble
// - busy          out  1       high in every state except IDLE
// - done          out  1       one-cycle pulse after the last nibble handshake
// - err           out  1       one-cycle pulse when a start is rejected
// BEHAVIOUR
// - Reset: state IDLE; all outputs 0; internal counters 0. Takes priority over any other event.
// - A reset mid-fetch abandons the fetch. State is IDLE on the next edge, with no done pulse.
// - IDLE, start=1 with a valid index: latch base address and word count, go to ADDR.
//   - Base = idx*(HID_WORDS+1) for hidden; HID_NEURONS*(HID_WORDS+1) + idx*(OUT_WORDS+1) for output.
// - Invalid index (hidden >= HID_NEURONS, output >= OUT_NEURONS): err=1 for one cycle, stay IDLE.
//   - No flash access occurs (fm_ce stays 0).
// - ADDR: fm_ce=fm_oe=1; fm_address held stable for exactly READ_WAIT cycles.
//   - On the last cycle, fm_data is registered into word_reg.
//   - The first word goes to BIAS; every later word goes to WEIGHT.
// - BIAS: bias=word_reg, bias_valid=1; on bias_ready, go to ADDR with address+1.
// - WEIGHT: weight=word_reg[15:12], then [11:8], [7:4], [3:0]. The MSB nibble goes first.
//   - Advance one nibble per weight_valid&&weight_ready.
//   - After the 4th handshake: go to ADDR with address+1 if words remain, else go to DONE.
//   - weight and weight_valid stay stable while weight_ready=0.
// - DONE: done=1 for one cycle, then IDLE. The next start is accepted the following cycle.
// - No prefetch: the next flash read starts only after all 4 nibbles of the current word are consumed.
// - start asserted in any non-IDLE state is ignored. It is not queued, and err stays 0.
// - Timing with ready inputs tied 1 and READ_WAIT=2, start sampled at cycle 0:
//   - hidden neuron: done at cycle 220;
//   - output neuron: done at cycle 16.
// TESTING
// - Hidden layer, idx 0, readies=1 -> addrs 0..36 in order; bias=mem[0]; 144 nibbles MSB-first; done @220.
// - Output layer, idx 9 -> addrs 323,324,325 only; bias=mem[323]; 8 nibbles; done @16; fm_we always 0.
// - weight_ready toggling 1-of-3 cycles -> no nibble lost or duplicated; fm_address stable until all 4 consumed.
// - Start with layer=0 idx=8, and with layer=1 idx=10 -> err pulse 1 cycle; fm_ce stays 0; busy stays 0.
// - rst for 1 cycle mid-weight stream -> all outputs 0 next cycle; new start on hidden idx 7 fetches from addr 259.
// - start re-asserted while busy -> ignored; a single done pulse; next start accepted the cycle after done.

Source files
------------

// File: rtl/neuron_param_fetcher.sv
// Fetches one neuron's bias and packed 4-bit weights from external flash and
// streams them to the MAC datapath over valid/ready handshakes.
module neuron_param_fetcher #(
   parameter int unsigned ADDR_W      = 16,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned READ_WAIT   = 2,
   parameter int unsigned HID_NEURONS = 8,
   parameter int unsigned HID_WORDS   = 36,
   parameter int unsigned OUT_NEURONS = 10,
   parameter int unsigned OUT_WORDS   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              layer,
   input  logic [3:0]        neuron_idx,
   input  logic [DATA_W-1:0] fm_data,
   output logic [ADDR_W-1:0] fm_address,
   output logic              fm_ce,
   output logic              fm_oe,
   output logic              fm_we,
   output logic [DATA_W-1:0] bias,
   output logic              bias_valid,
   input  logic              bias_ready,
   output logic [3:0]        weight,
   output logic              weight_valid,
   input  logic              weight_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned WAIT_W = $clog2(READ_WAIT + 1);
   localparam int unsigned CNT_W  = $clog2(HID_WORDS + OUT_WORDS + 1);
   localparam int unsigned NIBS   = DATA_W / 4;
   localparam int unsigned NIB_W  = (NIBS > 1) ? $clog2(NIBS) : 1;

   localparam logic [ADDR_W-1:0] HID_STRIDE = ADDR_W'(HID_WORDS + 1);
   localparam logic [ADDR_W-1:0] OUT_STRIDE = ADDR_W'(OUT_WORDS + 1);
   localparam logic [ADDR_W-1:0] OUT_BASE   = ADDR_W'(HID_NEURONS * (HID_WORDS + 1));

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_BIAS,
      S_WEIGHT,
      S_DONE
   } state_t;

   state_t              state;
   logic [WAIT_W-1:0]   wait_cnt;
   logic [CNT_W-1:0]    words_left;
   logic [NIB_W-1:0]    nib_cnt;
   logic [DATA_W-1:0]   word_reg;
   logic                is_bias;

   logic                idx_valid;
   logic [ADDR_W-1:0]   base_addr;
   logic [CNT_W-1:0]    word_total;

   always_comb begin
      idx_valid  = 1'b0;
      base_addr  = '0;
      word_total = '0;
      if (layer) begin
         idx_valid  = 32'(neuron_idx) < OUT_NEURONS;
         base_addr  = OUT_BASE + ADDR_W'(neuron_idx) * OUT_STRIDE;
         word_total = CNT_W'(OUT_WORDS);
      end else begin
         idx_valid  = 32'(neuron_idx) < HID_NEURONS;
         base_addr  = ADDR_W'(neuron_idx) * HID_STRIDE;
         word_total = CNT_W'(HID_WORDS);
      end
   end

   assign fm_we = 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         words_left   <= '0;
         nib_cnt      <= '0;
         word_reg     <= '0;
         is_bias      <= 1'b0;
         fm_address   <= '0;
         fm_ce        <= 1'b0;
         fm_oe        <= 1'b0;
         bias         <= '0;
         bias_valid   <= 1'b0;
         weight       <= '0;
         weight_valid <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (idx_valid) begin
                     fm_address <= base_addr;
                     words_left <= word_total;
                     wait_cnt   <= '0;
                     is_bias    <= 1'b1;
                     fm_ce      <= 1'b1;
                     fm_oe      <= 1'b1;
                     busy       <= 1'b1;
                     state      <= S_ADDR;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            S_ADDR: begin
               if (wait_cnt == WAIT_W'(READ_WAIT - 1)) begin
                  wait_cnt <= '0;
                  fm_ce    <= 1'b0;
                  fm_oe    <= 1'b0;
                  if (is_bias) begin
                     word_reg   <= fm_data;
                     bias       <= fm_data;
                     bias_valid <= 1'b1;
                     state      <= S_BIAS;
                  end else begin
                     // word_reg holds the not-yet-presented nibbles, MSB-aligned
                     word_reg     <= fm_data << 4;
                     weight       <= fm_data[DATA_W-1 -: 4];
                     weight_valid <= 1'b1;
                     nib_cnt      <= '0;
                     state        <= S_WEIGHT;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            S_BIAS: begin
               if (bias_ready) begin
                  bias_valid <= 1'b0;
                  is_bias    <= 1'b0;
                  fm_address <= fm_address + 1'b1;
                  fm_ce      <= 1'b1;
                  fm_oe      <= 1'b1;
                  state      <= S_ADDR;
               end
            end
            S_WEIGHT: begin
               if (weight_ready) begin
                  if (nib_cnt == NIB_W'(NIBS - 1)) begin
                     weight_valid <= 1'b0;
                     words_left   <= words_left - 1'b1;
                     if (words_left == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                     end else begin
                        fm_address <= fm_address + 1'b1;
                        fm_ce      <= 1'b1;
                        fm_oe      <= 1'b1;
                        state      <= S_ADDR;
                     end
                  end else begin
                     nib_cnt  <= nib_cnt + 1'b1;
                     weight   <= word_reg[DATA_W-1 -: 4];
                     word_reg <= word_reg << 4;
                  end
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_param_fetcher.sv
// Bench for neuron_param_fetcher: a behavioural flash image plus queues of
// expected addresses, bias words and nibbles consumed as the DUT handshakes.
module tb_neuron_param_fetcher;

   localparam int READ_WAIT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        layer;
   logic [3:0]  neuron_idx;
   logic [15:0] fm_data;
   logic [15:0] fm_address;
   logic        fm_ce, fm_oe, fm_we;
   logic [15:0] bias;
   logic        bias_valid, bias_ready;
   logic [3:0]  weight;
   logic        weight_valid, weight_ready;
   logic        busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_addr_q[$];
   logic [15:0] exp_bias_q[$];
   logic [3:0]  exp_nib_q[$];

   always #5 clk = ~clk;

   neuron_param_fetcher #(
      .ADDR_W(16), .DATA_W(16), .READ_WAIT(READ_WAIT),
      .HID_NEURONS(8), .HID_WORDS(36), .OUT_NEURONS(10), .OUT_WORDS(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .layer(layer), .neuron_idx(neuron_idx),
      .fm_data(fm_data), .fm_address(fm_address), .fm_ce(fm_ce), .fm_oe(fm_oe),
      .fm_we(fm_we), .bias(bias), .bias_valid(bias_valid), .bias_ready(bias_ready),
      .weight(weight), .weight_valid(weight_valid), .weight_ready(weight_ready),
      .busy(busy), .done(done), .err(err)
   );

   function automatic logic [15:0] flash_word(input logic [15:0] a);
      return (a * 16'd40503) ^ 16'h1b5c;
   endfunction

   assign fm_data = flash_word(fm_address);

   task automatic push_expect(input logic lay, input logic [3:0] idx);
      int base, nw;
      logic [15:0] w;
      base = lay ? 296 + int'(idx) * 3 : int'(idx) * 37;
      nw   = lay ? 2 : 36;
      for (int i = 0; i <= nw; i++) exp_addr_q.push_back(16'(base + i));
      exp_bias_q.push_back(flash_word(16'(base)));
      for (int i = 1; i <= nw; i++) begin
         w = flash_word(16'(base + i));
         for (int n = 3; n >= 0; n--) exp_nib_q.push_back(w[n*4 +: 4]);
      end
   endtask

   // mode 0: readies tied high; mode 1: readies high one cycle in three
   task automatic run_fetch(input logic lay, input logic [3:0] idx, input int mode,
                            input int exp_done, input bit noise);
      int cyc, ce_run;
      bit fin;
      logic prev_ce;
      logic [15:0] prev_addr, ea;
      logic [15:0] eb;
      logic [3:0] en;
      push_expect(lay, idx);
      layer = lay; neuron_idx = idx; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; cyc = 1; ce_run = 0; fin = 0; prev_ce = 1'b0; prev_addr = '0;
      while (!fin && cyc < 2000) begin
         bias_ready   = (mode == 0) || (cyc % 3 == 0);
         weight_ready = (mode == 0) || (cyc % 3 == 0);
         n_checks++;
         if (fm_we !== 1'b0 || fm_oe !== fm_ce) begin
            n_fail++; $display("FAIL flash_ctrl cyc=%0d we=%b oe=%b ce=%b", cyc, fm_we, fm_oe, fm_ce);
         end
         n_checks++;
         if (busy !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL busy_err cyc=%0d busy=%b err=%b expected 1/0", cyc, busy, err);
         end
         if (fm_ce) begin
            if (!prev_ce) begin
               n_checks++;
               if (exp_addr_q.size() == 0) begin
                  n_fail++; $display("FAIL addr_extra cyc=%0d got %0d expected none", cyc, fm_address);
               end else begin
                  ea = exp_addr_q.pop_front();
                  if (fm_address !== ea) begin
                     n_fail++; $display("FAIL addr_order cyc=%0d got %0d expected %0d", cyc, fm_address, ea);
                  end
               end
            end else begin
               n_checks++;
               if (fm_address !== prev_addr) begin
                  n_fail++; $display("FAIL addr_stable cyc=%0d got %0d expected %0d", cyc, fm_address, prev_addr);
               end
            end
            ce_run++;
            n_checks++;
            if (weight_valid !== 1'b0 || bias_valid !== 1'b0) begin
               n_fail++; $display("FAIL prefetch cyc=%0d wv=%b bv=%b expected 0/0", cyc, weight_valid, bias_valid);
            end
         end else if (prev_ce) begin
            n_checks++;
            if (ce_run != READ_WAIT) begin
               n_fail++; $display("FAIL read_len cyc=%0d got %0d expected %0d", cyc, ce_run, READ_WAIT);
            end
            ce_run = 0;
         end
         prev_ce = fm_ce; prev_addr = fm_address;
         if (bias_valid && bias_ready) begin
            n_checks++;
            if (exp_bias_q.size() == 0) begin
               n_fail++; $display("FAIL bias_extra cyc=%0d got %h expected none", cyc, bias);
            end else begin
               eb = exp_bias_q.pop_front();
               if (bias !== eb) begin
                  n_fail++; $display("FAIL bias_value cyc=%0d got %h expected %h", cyc, bias, eb);
               end
            end
         end
         if (weight_valid && weight_ready) begin
            n_checks++;
            if (exp_nib_q.size() == 0) begin
               n_fail++; $display("FAIL nib_extra cyc=%0d got %h expected none", cyc, weight);
            end else begin
               en = exp_nib_q.pop_front();
               if (weight !== en) begin
                  n_fail++; $display("FAIL nib_value cyc=%0d got %h expected %h", cyc, weight, en);
               end
            end
         end
         if (done) begin
            fin = 1;
            if (exp_done > 0) begin
               n_checks++;
               if (cyc != exp_done) begin
                  n_fail++; $display("FAIL done_cycle got %0d expected %0d", cyc, exp_done);
               end
            end
            start = noise;
         end else begin
            start = noise && (cyc % 5 == 2);
            if (noise) neuron_idx = 4'(cyc % 8);
            @(posedge clk); #1;
            cyc++;
         end
      end
      n_checks++;
      if (!fin) begin
         n_fail++; $display("FAIL done_timeout got none expected done within 2000 cycles");
      end
      // start may still be high here: the DONE edge must not accept it
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL after_done done=%b busy=%b expected 0/0", done, busy);
      end
      n_checks++;
      if (exp_addr_q.size() != 0 || exp_bias_q.size() != 0 || exp_nib_q.size() != 0) begin
         n_fail++; $display("FAIL leftover addr=%0d bias=%0d nib=%0d expected 0/0/0",
                            exp_addr_q.size(), exp_bias_q.size(), exp_nib_q.size());
      end
      exp_addr_q.delete(); exp_bias_q.delete(); exp_nib_q.delete();
   endtask

   task automatic check_all_zero(input string name);
      n_checks++;
      if ({fm_address, fm_ce, fm_oe, fm_we, bias, bias_valid, weight, weight_valid, busy, done, err} !== '0) begin
         n_fail++;
         $display("FAIL %s addr=%h ce=%b oe=%b we=%b bias=%h bv=%b w=%h wv=%b busy=%b done=%b err=%b expected all 0",
                  name, fm_address, fm_ce, fm_oe, fm_we, bias, bias_valid, weight, weight_valid, busy, done, err);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; start = 1'b0; layer = 1'b0; neuron_idx = '0;
      bias_ready = 1'b0; weight_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_state");
      rst = 1'b0;
      @(posedge clk); #1;
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_hidden;
      run_fetch(1'b0, 4'd0, 0, 220, 1'b0);
   endtask

   task automatic test_output;
      run_fetch(1'b1, 4'd9, 0, 16, 1'b0);
   endtask

   task automatic test_backpressure;
      run_fetch(1'b1, 4'd3, 1, 0, 1'b0);
      run_fetch(1'b0, 4'd2, 1, 0, 1'b0);
   endtask

   task automatic test_invalid_index;
      logic lays[2];
      logic [3:0] idxs[2];
      lays[0] = 1'b0; idxs[0] = 4'd8;
      lays[1] = 1'b1; idxs[1] = 4'd10;
      for (int k = 0; k < 2; k++) begin
         layer = lays[k]; neuron_idx = idxs[k]; start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         n_checks++;
         if (err !== 1'b1 || busy !== 1'b0 || fm_ce !== 1'b0) begin
            n_fail++; $display("FAIL err_pulse case=%0d err=%b busy=%b ce=%b expected 1/0/0", k, err, busy, fm_ce);
         end
         for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (err !== 1'b0 || busy !== 1'b0 || fm_ce !== 1'b0) begin
               n_fail++; $display("FAIL err_after case=%0d err=%b busy=%b ce=%b expected 0/0/0", k, err, busy, fm_ce);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      int c;
      bias_ready = 1'b1; weight_ready = 1'b1;
      layer = 1'b0; neuron_idx = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      c = 0;
      while (!weight_valid && c < 50) begin
         @(posedge clk); #1;
         c++;
      end
      n_checks++;
      if (weight_valid !== 1'b1) begin
         n_fail++; $display("FAIL reach_weights got wv=%b expected 1", weight_valid);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_all_zero("mid_reset");
      repeat (3) begin
         @(posedge clk); #1;
         check_all_zero("post_reset_idle");
      end
      run_fetch(1'b0, 4'd7, 0, 220, 1'b0);
   endtask

   task automatic test_back_to_back;
      run_fetch(1'b1, 4'd4, 0, 16, 1'b1);
      run_fetch(1'b1, 4'd5, 0, 16, 1'b0);
      run_fetch(1'b0, 4'd3, 0, 220, 1'b1);
   endtask

   initial begin
      test_reset;
      test_hidden;
      test_output;
      test_backpressure;
      test_invalid_index;
      test_reset_mid;
      test_back_to_back;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
